ti_adc_os_cal: RTL and testbench

Digital background offset-calibration controller for the time-interleaved SAR ADC. During a calibration window the ADC inputs are shorted to VCM. The block consumes the per-way ADC output words on the ADC core clock and averages each way's error against mid-code. It then trims that way's sense-amp offset DAC codes (data_vosp/data_vosn) and loops until every way converges or an iteration limit is reached. It sits in the core-clock domain and closes the loop the ADC opens: ADC data in, offset codes out. A manual write path lets scan/config logic load codes directly.

---
 rtl/ti_adc_cal_pkg.sv | 45 ++++
 rtl/ti_adc_os_cal_way.sv | 104 ++++++++++
 rtl/ti_adc_os_cal.sv | 154 +++++++++++++++
 tb/tb_ti_adc_os_cal.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_adc_cal_pkg.sv
// Shared types and helpers for the time-interleaved ADC offset calibration
// controller: FSM state encoding, default geometry and saturating code math.
package ti_adc_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_UPDATE,
        ST_DONE
    } cal_state_e;

    localparam int DEF_ADC_BITS  = 9;
    localparam int DEF_ACC_LOG2  = 6;
    localparam int DEF_MID_CODE  = 2 ** (DEF_ADC_BITS - 1);
    localparam int DEF_ACC_WIDTH = DEF_ADC_BITS + DEF_ACC_LOG2 + 1;

    // Offset-binary mid-code for a given word width.
    function automatic int mid_code(input int adc_bits);
        return 2 ** (adc_bits - 1);
    endfunction

    // One sign bit plus enough headroom for 2^acc_log2 full-scale errors.
    function automatic int acc_width(input int adc_bits, input int acc_log2);
        return adc_bits + acc_log2 + 1;
    endfunction

    // Add step, clamping at max_code.
    function automatic int unsigned sat_add(input int unsigned code,
                                            input int unsigned step,
                                            input int unsigned max_code);
        if (code > max_code - step)
            return max_code;
        return code + step;
    endfunction

    // Subtract step, clamping at zero.
    function automatic int unsigned sat_sub(input int unsigned code,
                                            input int unsigned step);
        if (code < step)
            return 0;
        return code - step;
    endfunction

endpackage

// File: rtl/ti_adc_os_cal_way.sv
// One interleaved way: signed error accumulator against mid-code, averaged
// deadband compare, and the vosp/vosn code pair with per-rail saturation.
module ti_adc_os_cal_way
    import ti_adc_cal_pkg::*;
#(
    parameter int ADC_BITS   = DEF_ADC_BITS,
    parameter int OSDAC_BITS = 8,
    parameter int OS_INIT    = 128,
    parameter int ACC_LOG2   = DEF_ACC_LOG2,
    parameter int DEADBAND   = 1,
    parameter int STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADC_BITS-1:0]   sample,
    input  logic                  acc_clr,
    input  logic                  acc_en,
    input  logic                  upd,
    input  logic                  conv_clr,
    input  logic                  load,
    input  logic [OSDAC_BITS-1:0] load_vosp,
    input  logic [OSDAC_BITS-1:0] load_vosn,
    output logic [OSDAC_BITS-1:0] vosp,
    output logic [OSDAC_BITS-1:0] vosn,
    output logic                  conv,
    output logic                  conv_now
);

    localparam int ACC_W = acc_width(ADC_BITS, ACC_LOG2);
    localparam int unsigned CODE_MAX = (2 ** OSDAC_BITS) - 1;
    localparam logic signed [ADC_BITS:0] MID = (ADC_BITS + 1)'(mid_code(ADC_BITS));
    localparam logic signed [ACC_W-1:0] DB_POS = ACC_W'(DEADBAND);
    localparam logic signed [ACC_W-1:0] DB_NEG = -DB_POS;

    logic signed [ADC_BITS:0] err;
    logic signed [ACC_W-1:0]  err_ext;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  avg;
    logic                     err_hi;
    logic                     err_lo;
    logic [OSDAC_BITS-1:0]    vosp_reg;
    logic [OSDAC_BITS-1:0]    vosn_reg;
    logic                     conv_reg;
    logic [OSDAC_BITS-1:0]    vosp_up;
    logic [OSDAC_BITS-1:0]    vosp_dn;
    logic [OSDAC_BITS-1:0]    vosn_up;
    logic [OSDAC_BITS-1:0]    vosn_dn;

    assign err      = $signed({1'b0, sample}) - MID;
    assign err_ext  = {{(ACC_W - ADC_BITS - 1){err[ADC_BITS]}}, err};
    assign avg      = acc_reg >>> ACC_LOG2;
    assign err_hi   = avg > DB_POS;
    assign err_lo   = avg < DB_NEG;
    assign conv_now = !err_hi && !err_lo;

    assign vosp_up = OSDAC_BITS'(sat_add(32'(vosp_reg), STEP, CODE_MAX));
    assign vosp_dn = OSDAC_BITS'(sat_sub(32'(vosp_reg), STEP));
    assign vosn_up = OSDAC_BITS'(sat_add(32'(vosn_reg), STEP, CODE_MAX));
    assign vosn_dn = OSDAC_BITS'(sat_sub(32'(vosn_reg), STEP));

    // Error accumulator: cleared while settling, summed during the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_reg <= '0;
        else if (acc_clr)
            acc_reg <= '0;
        else if (acc_en)
            acc_reg <= acc_reg + err_ext;
    end

    // Offset codes: manual load when idle, otherwise one step against the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vosp_reg <= OSDAC_BITS'(OS_INIT);
            vosn_reg <= OSDAC_BITS'(OS_INIT);
        end else if (load) begin
            vosp_reg <= load_vosp;
            vosn_reg <= load_vosn;
        end else if (upd) begin
            if (err_hi) begin
                vosp_reg <= vosp_dn;
                vosn_reg <= vosn_up;
            end else if (err_lo) begin
                vosp_reg <= vosp_up;
                vosn_reg <= vosn_dn;
            end
        end
    end

    // Converged flag reflects the most recent update decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conv_reg <= 1'b0;
        else if (conv_clr)
            conv_reg <= 1'b0;
        else if (upd)
            conv_reg <= conv_now;
    end

    assign vosp = vosp_reg;
    assign vosn = vosn_reg;
    assign conv = conv_reg;

endmodule

// File: rtl/ti_adc_os_cal.sv
// Background offset calibration controller: sequences settle / accumulate /
// update iterations across all ways and decodes the manual code-write path.
module ti_adc_os_cal
    import ti_adc_cal_pkg::*;
#(
    parameter int ADC_WAYS   = 8,
    parameter int ADC_BITS   = DEF_ADC_BITS,
    parameter int OSDAC_BITS = 8,
    parameter int OS_INIT    = 128,
    parameter int ACC_LOG2   = DEF_ACC_LOG2,
    parameter int SETTLE_CYC = 4,
    parameter int DEADBAND   = 1,
    parameter int STEP       = 1,
    parameter int MAX_ITER   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADC_BITS-1:0]           adc_data [0:ADC_WAYS-1],
    input  logic                          cal_start,
    input  logic                          cal_abort,
    input  logic                          cfg_wr,
    input  logic [$clog2(ADC_WAYS)-1:0]   cfg_way,
    input  logic [OSDAC_BITS-1:0]         cfg_vosp,
    input  logic [OSDAC_BITS-1:0]         cfg_vosn,
    output logic [OSDAC_BITS-1:0]         data_vosp [0:ADC_WAYS-1],
    output logic [OSDAC_BITS-1:0]         data_vosn [0:ADC_WAYS-1],
    output logic                          cal_busy,
    output logic                          cal_done,
    output logic [0:ADC_WAYS-1]           cal_conv,
    output logic [$clog2(MAX_ITER+1)-1:0] cal_iter
);

    localparam int WAY_W  = $clog2(ADC_WAYS);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int ACC_N  = 2 ** ACC_LOG2;
    localparam int CNT_W  = $clog2(ACC_N + SETTLE_CYC + 1);

    cal_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic              acc_clr, acc_en, upd, conv_clr, cfg_ok, busy;
    logic [0:ADC_WAYS-1] conv_now;

    assign busy = (state_reg == ST_SETTLE) || (state_reg == ST_ACCUM) ||
                  (state_reg == ST_UPDATE);

    // State, phase counter and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            iter_reg  <= iter_next;
        end
    end

    // Next-state and per-way strobes; abort overrides everything while busy.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        iter_next  = iter_reg;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        upd        = 1'b0;
        conv_clr   = 1'b0;
        cfg_ok     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                cfg_ok = 1'b1;
                if (cal_start) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                    iter_next  = '0;
                    conv_clr   = 1'b1;
                end
            end
            ST_SETTLE: begin
                acc_clr = 1'b1;
                if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
                    state_next = ST_ACCUM;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_ACCUM: begin
                acc_en = 1'b1;
                if (cnt_reg == CNT_W'(ACC_N - 1)) begin
                    state_next = ST_UPDATE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_UPDATE: begin
                upd       = 1'b1;
                iter_next = iter_reg + 1'b1;
                if ((&conv_now) || (iter_reg == ITER_W'(MAX_ITER - 1)))
                    state_next = ST_DONE;
                else
                    state_next = ST_SETTLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (busy && cal_abort) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            iter_next  = iter_reg;
            acc_clr    = 1'b0;
            acc_en     = 1'b0;
            upd        = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < ADC_WAYS; gi++) begin : g_way
            logic load;
            // Way index decode; indices beyond the last way never match.
            assign load = cfg_ok && cfg_wr && (cfg_way == WAY_W'(gi));

            ti_adc_os_cal_way #(
                .ADC_BITS   (ADC_BITS),
                .OSDAC_BITS (OSDAC_BITS),
                .OS_INIT    (OS_INIT),
                .ACC_LOG2   (ACC_LOG2),
                .DEADBAND   (DEADBAND),
                .STEP       (STEP)
            ) u_way (
                .clk        (clk),
                .rst_n      (rst_n),
                .sample     (adc_data[gi]),
                .acc_clr    (acc_clr),
                .acc_en     (acc_en),
                .upd        (upd),
                .conv_clr   (conv_clr),
                .load       (load),
                .load_vosp  (cfg_vosp),
                .load_vosn  (cfg_vosn),
                .vosp       (data_vosp[gi]),
                .vosn       (data_vosn[gi]),
                .conv       (cal_conv[gi]),
                .conv_now   (conv_now[gi])
            );
        end
    endgenerate

    assign cal_busy = busy;
    assign cal_done = (state_reg == ST_DONE);
    assign cal_iter = iter_reg;

endmodule

// File: tb/tb_ti_adc_os_cal.sv
// Scoreboard bench for ti_adc_os_cal: each scenario queues its expected
// results, runs a calibration, then pops and compares once the DUT finishes.
module tb_ti_adc_os_cal;

    localparam int WAYS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] adc_data [0:WAYS-1];
    logic       cal_start = 1'b0;
    logic       cal_abort = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_way = '0;
    logic [7:0] cfg_vosp = '0;
    logic [7:0] cfg_vosn = '0;
    logic [7:0] data_vosp [0:WAYS-1];
    logic [7:0] data_vosn [0:WAYS-1];
    logic       cal_busy;
    logic       cal_done;
    logic [0:WAYS-1] cal_conv;
    logic [5:0] cal_iter;

    ti_adc_os_cal dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .cal_start (cal_start),
        .cal_abort (cal_abort),
        .cfg_wr    (cfg_wr),
        .cfg_way   (cfg_way),
        .cfg_vosp  (cfg_vosp),
        .cfg_vosn  (cfg_vosn),
        .data_vosp (data_vosp),
        .data_vosn (data_vosn),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_conv  (cal_conv),
        .cal_iter  (cal_iter)
    );

    initial forever #5 clk = ~clk;

    // Plant model per way: 0 = constant, 1 = alternating 255/257,
    // 2 = closed loop with offset 5 - (128 - vosp) around mid-code 256.
    int mode [WAYS];
    int cval [WAYS];
    bit alt_ph = 1'b0;

    initial begin
        for (int w = 0; w < WAYS; w++) begin
            mode[w] = 0;
            cval[w] = 256;
        end
        forever begin
            for (int w = 0; w < WAYS; w++) begin
                case (mode[w])
                    1:       adc_data[w] = alt_ph ? 9'd257 : 9'd255;
                    2:       adc_data[w] = 9'(133 + int'(data_vosp[w]));
                    default: adc_data[w] = 9'(cval[w]);
                endcase
            end
            @(posedge clk);
            #1;
            alt_ph = ~alt_ph;
        end
    end

    typedef struct {
        string tag;
        int    sel;
        int    way;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_cycles = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int observe(input int sel, input int way);
        case (sel)
            0:       return int'(data_vosp[way]);
            1:       return int'(data_vosn[way]);
            2:       return int'(cal_conv[way]);
            3:       return int'(cal_iter);
            4:       return int'(cal_conv);
            5:       return int'(cal_busy);
            6:       return int'(cal_done);
            default: return last_cycles;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int way, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.way = way;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic expect_way(input string tag, input int w, input int vp, input int vn, input int cv);
        push($sformatf("%s vosp[%0d]", tag, w), 0, w, vp);
        push($sformatf("%s vosn[%0d]", tag, w), 1, w, vn);
        push($sformatf("%s conv[%0d]", tag, w), 2, w, cv);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel, e.way), e.val);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            mode[w] = 0;
            cval[w] = 256;
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Pulse cal_start (optionally with a same-cycle cfg_wr), then count clock
    // edges after the sampling edge until cal_done. At edge inject_at a
    // cfg_wr + cal_start pair is driven that a busy DUT must ignore.
    task automatic run_cal(input bit with_cfg, input int inject_at, input int max_cyc);
        bit done = 1'b0;
        bit clr_pending = 1'b0;
        @(negedge clk);
        cal_start = 1'b1;
        cfg_wr    = with_cfg;
        @(posedge clk);
        #1;
        cal_start = 1'b0;
        cfg_wr    = 1'b0;
        last_cycles = 0;
        while (!done && last_cycles < max_cyc) begin
            @(posedge clk);
            #1;
            last_cycles++;
            if (clr_pending) begin
                cfg_wr      = 1'b0;
                cal_start   = 1'b0;
                clr_pending = 1'b0;
            end
            if (cal_done) begin
                done = 1'b1;
            end else if (last_cycles == inject_at) begin
                cfg_way     = 3'd3;
                cfg_vosp    = 8'd7;
                cfg_vosn    = 8'd9;
                cfg_wr      = 1'b1;
                cal_start   = 1'b1;
                clr_pending = 1'b1;
            end
        end
        cfg_wr    = 1'b0;
        cal_start = 1'b0;
        check_eq("done_within_bound", int'(done), 1);
    endtask

    initial begin
        // Reset state, including while reset is still asserted.
        #12;
        push("in_reset busy", 5, 0, 0);
        push("in_reset vosp[0]", 0, 0, 128);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            push("post_reset busy", 5, 0, 0);
            push("post_reset done", 6, 0, 0);
            push("post_reset iter", 3, 0, 0);
            push("post_reset conv", 4, 0, 0);
            drain();
        end
        for (int w = 0; w < WAYS; w++) expect_way("reset", w, 128, 128, 0);
        drain();

        // All ways at mid-code: one iteration, everything converged.
        do_reset();
        push("mid cycles", 7, 0, 69);
        push("mid iter", 3, 0, 1);
        push("mid conv", 4, 0, 255);
        push("mid vosp[4]", 0, 4, 128);
        push("mid vosn[4]", 1, 4, 128);
        run_cal(1'b0, 0, 200);
        drain();

        // Way 2 stuck 10 LSB high, open loop: runs to the iteration limit.
        do_reset();
        cval[2] = 266;
        push("open cycles", 7, 0, 32 * 69);
        push("open iter", 3, 0, 32);
        push("open done", 6, 0, 1);
        for (int w = 0; w < WAYS; w++)
            expect_way("open", w, (w == 2) ? 96 : 128, (w == 2) ? 160 : 128, (w == 2) ? 0 : 1);
        run_cal(1'b0, 0, 3000);
        drain();

        // Manual write in the start cycle, then both rails saturate.
        do_reset();
        cval[5]  = 300;
        cfg_way  = 3'd5;
        cfg_vosp = 8'd1;
        cfg_vosn = 8'd254;
        push("sat iter", 3, 0, 32);
        for (int w = 0; w < WAYS; w++)
            expect_way("sat", w, (w == 5) ? 0 : 128, (w == 5) ? 255 : 128, (w == 5) ? 0 : 1);
        run_cal(1'b1, 0, 3000);
        drain();

        // Closed loop: error 5,4,3,2 trimmed, then 1 LSB lies inside the deadband.
        do_reset();
        for (int w = 0; w < WAYS; w++) mode[w] = 2;
        push("loop cycles", 7, 0, 5 * 69);
        push("loop iter", 3, 0, 5);
        push("loop conv", 4, 0, 255);
        for (int w = 0; w < WAYS; w += 3) expect_way("loop", w, 124, 132, 1);
        run_cal(1'b0, 0, 1000);
        drain();

        // Abort during the second accumulation window.
        do_reset();
        cval[0] = 270;
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1;
        cal_start = 1'b0;
        repeat (83) @(posedge clk);
        #1;
        push("abort pre busy", 5, 0, 1);
        drain();
        cal_abort = 1'b1;
        @(posedge clk);
        #1;
        cal_abort = 1'b0;
        push("abort busy", 5, 0, 0);
        push("abort done", 6, 0, 0);
        push("abort iter", 3, 0, 1);
        expect_way("abort", 0, 127, 129, 0);
        push("abort conv[1]", 2, 1, 1);
        drain();
        repeat (100) @(posedge clk);
        #1;
        push("abort hold busy", 5, 0, 0);
        expect_way("abort_hold", 0, 127, 129, 0);
        drain();

        // Write and restart attempts while busy must be ignored.
        do_reset();
        push("busy cycles", 7, 0, 69);
        push("busy iter", 3, 0, 1);
        expect_way("busy", 3, 128, 128, 1);
        run_cal(1'b0, 20, 200);
        drain();

        // Alternating 255/257 averages to zero error.
        do_reset();
        for (int w = 0; w < WAYS; w++) mode[w] = 1;
        push("alt cycles", 7, 0, 69);
        push("alt iter", 3, 0, 1);
        push("alt conv", 4, 0, 255);
        expect_way("alt", 6, 128, 128, 1);
        run_cal(1'b0, 0, 200);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
